// File: rtl/vme_cmd_arbiter.sv
// Round-robin arbiter sharing the VME command/data register port among NREQ requesters.
// Issues one command at a time, then waits for the completion strobe or a timeout.
module vme_cmd_arbiter #(
   parameter int          NREQ    = 2,
   parameter logic [31:0] MASK    = 32'h00a80000,
   parameter int          TIMEOUT = 1024,
   parameter int          TO_W    = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*16-1:0]   req_cmd,
   input  logic [NREQ*16-1:0]   req_wdata,
   input  logic [NREQ-1:0]      req_rnw,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic                 err,
   output logic [15:0]          rd_data,
   output logic                 busy,
   output logic [7:0]           err_cnt,
   input  logic                 vme_cmd_rd,
   output logic                 start,
   output logic [31:0]          vme_cmd_reg,
   output logic [31:0]          vme_dat_reg_in,
   input  logic                 vme_dat_wr,
   input  logic [31:0]          vme_dat_reg_out
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
   localparam logic [31:0] RD_BIT = 32'h0200_0000;
   localparam logic [31:0] WR_BIT = 32'h0100_0000;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   win;
   logic [TO_W-1:0] to_cnt;
   logic            rnw_q;
   logic            timeout_hit;

   // Nearest asserted request after ptr wins; scanning far-to-near lets the nearest overwrite.
   function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
      logic [PW-1:0] w;
      int            idx;
      w = p;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(p) + k) % NREQ;
         if (r[idx]) w = PW'(idx);
      end
      return w;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

   assign win = rr_pick(req, ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      timeout_hit = 1'b0;
      case (state)
         S_IDLE:  if (|req && vme_cmd_rd) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (vme_dat_wr) begin
               state_nxt = S_DONE;
            end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt            <= '0;
         done           <= '0;
         err            <= 1'b0;
         start          <= 1'b0;
         busy           <= 1'b0;
         rd_data        <= '0;
         err_cnt        <= '0;
         vme_cmd_reg    <= MASK;
         vme_dat_reg_in <= '0;
         ptr            <= PW'(NREQ - 1);
         to_cnt         <= '0;
         rnw_q          <= 1'b0;
      end else begin
         start <= (state_nxt == S_ISSUE);
         busy  <= (state_nxt != S_IDLE);
         done  <= '0;
         err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (state_nxt == S_ISSUE) begin
                  vme_cmd_reg    <= MASK | {16'h0, req_cmd[int'(win)*16 +: 16]} |
                                    (req_rnw[win] ? RD_BIT : WR_BIT);
                  vme_dat_reg_in <= {16'h0, req_wdata[int'(win)*16 +: 16]};
                  rnw_q          <= req_rnw[win];
                  gnt            <= NREQ'(1) << win;
                  ptr            <= win;
               end
            end
            S_ISSUE: to_cnt <= '0;
            S_WAIT: begin
               to_cnt <= to_cnt + 1'b1;
               if (state_nxt == S_DONE) begin
                  done           <= gnt;
                  err            <= timeout_hit;
                  vme_cmd_reg    <= MASK;
                  vme_dat_reg_in <= '0;
                  if (vme_dat_wr && rnw_q) rd_data <= vme_dat_reg_out[15:0];
                  if (timeout_hit) err_cnt <= sat_inc8(err_cnt);
               end
            end
            S_DONE:  gnt <= '0;
            default: gnt <= '0;
         endcase
      end
   end

endmodule
